// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared definitions for the register-file dump block.
//   state_t        - sequencing FSM states (IDLE, LOAD, SEND)
//   BYTES_PER_WORD - payload bytes per 32-bit register word
//   HDR_PREFIX     - upper bits of the optional per-register header byte
//   BYTES_PER_REG  - bytes actually sent per register (header included)
//   SHIFT_W        - width of the serializer shift register
// Build option: define RF_DUMP_INDEX_EN to prefix every register with an
// index header byte {HDR_PREFIX, index}.
package rf_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [2:0] HDR_PREFIX = 3'b000;

`ifdef RF_DUMP_INDEX_EN
  localparam int BYTES_PER_REG = BYTES_PER_WORD + 1;
`else
  localparam int BYTES_PER_REG = BYTES_PER_WORD;
`endif

  localparam int SHIFT_W = 8 * BYTES_PER_REG;

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
    return {HDR_PREFIX, idx};
  endfunction

endpackage

// File: rtl/rf_dump_ser.sv
// rf_dump_ser: byte serializer for one register word.
//   clk, rst     - clock, asynchronous active-high reset
//   load_i       - capture word_i (and index_i when headers are enabled)
//   word_i       - 32-bit register snapshot
//   index_i      - register index for the header byte (RF_DUMP_INDEX_EN only)
//   tx_ready_i   - downstream ready
//   tx_data_o    - current byte (top byte of the shift register)
//   tx_valid_o   - byte valid; held until accepted
//   last_o       - handshake on the final byte of this word (combinational)
// Build option: RF_DUMP_INDEX_EN adds the header byte in front of the word.
module rf_dump_ser
  import rf_dump_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
`ifdef RF_DUMP_INDEX_EN
  input  logic [4:0]  index_i,
`endif
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        last_o
);

  localparam logic [2:0] LAST_CNT = 3'(BYTES_PER_REG - 1);

  logic [31:0]        word_ord;
  logic [SHIFT_W-1:0] load_val;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               fire;

  // Bytes always leave from the top of the shift register, so arrange the
  // word so that the first byte to send sits in the top lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_order
      if (LSB_FIRST != 0) begin : g_lsb
        assign word_ord[8*gi +: 8] = word_i[8*(BYTES_PER_WORD-1-gi) +: 8];
      end else begin : g_msb
        assign word_ord[8*gi +: 8] = word_i[8*gi +: 8];
      end
    end
  endgenerate

`ifdef RF_DUMP_INDEX_EN
  assign load_val = {hdr_byte(index_i), word_ord};
`else
  assign load_val = word_ord;
`endif

  assign fire       = valid_q && tx_ready_i;
  assign last_o     = fire && (cnt_q == LAST_CNT);
  assign tx_data_o  = shift_q[SHIFT_W-1 -: 8];
  assign tx_valid_o = valid_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = load_val;
      cnt_d   = 3'd0;
      valid_d = 1'b1;
    end else if (fire) begin
      shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
      if (cnt_q == LAST_CNT) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rf_dump.sv
// rf_dump: streams a range of register-file entries out as bytes.
//   clk, rst         - clock, asynchronous active-high reset
//   start            - dump request, honoured only in IDLE (not on a done cycle)
//   lo_idx, hi_idx   - first/last register index, latched on start
//   reg_sel          - registered debug read select into the register file
//   reg_data         - combinational read data for reg_sel
//   tx_data/tx_valid/tx_ready - byte stream with valid/ready handshake
//   busy             - high whenever the FSM is not IDLE
//   done             - one-cycle pulse on return to IDLE after the last byte
// Parameter LSB_FIRST: 1 = little-endian byte order per word, 0 = big-endian.
// Build option: RF_DUMP_INDEX_EN prefixes each register with an index byte.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  lo_idx,
  input  logic [4:0]  hi_idx,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] hi_q, hi_d;
  logic       done_q, done_d;
  logic       load;
  logic       ser_last;

  // The current index doubles as the register-file select, so reg_sel is
  // registered and stays put for the whole LOAD cycle.
  assign reg_sel = idx_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          hi_d    = hi_idx;
          idx_d   = lo_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last) begin
          if (idx_q == hi_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 5'd1;  // wraps 31 -> 0
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      hi_q    <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  rf_dump_ser #(
    .LSB_FIRST(LSB_FIRST)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .word_i     (reg_data),
`ifdef RF_DUMP_INDEX_EN
    .index_i    (idx_q),
`endif
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .last_o     (ser_last)
  );

endmodule

// File: doc/rf_dump.md
RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 sends each register word least-significant byte first, 0 sends it most-significant byte first.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: dump request, sampled only in IDLE.
REQ-005 SHALL have ports lo_idx and hi_idx, input, 5 bits each: first and last register index, latched when start is accepted.
REQ-006 SHALL have port reg_sel, output, 5 bits: register-file debug read select, registered.
REQ-007 SHALL have port reg_data, input, 32 bits: combinational register-file debug read data for reg_sel.
REQ-008 SHALL have ports tx_data (output, 8 bits), tx_valid (output, 1 bit) and tx_ready (input, 1 bit): byte stream to the debug UART/host.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the final byte of a dump is accepted.

Function
REQ-011 SHALL implement states IDLE, LOAD, SEND.
- IDLE -> LOAD when start=1.
- LOAD -> SEND after one cycle.
- SEND -> LOAD after the last byte when the current index != hi.
- SEND -> IDLE after the last byte when the current index == hi.
REQ-012 SHALL, on accepting start, latch hi_idx, set the current index and reg_sel to lo_idx, and assert busy from the next cycle.
REQ-013 SHALL hold reg_sel stable for the whole LOAD cycle and capture reg_data into a 32-bit shift register at the end of LOAD.
REQ-014 SHALL assert tx_valid in SEND, starting the cycle after LOAD.
REQ-015 SHALL hold tx_data and tx_valid stable until tx_valid && tx_ready; one byte is transferred per handshake cycle.
REQ-016 SHALL never deassert tx_valid without a handshake, except on reset.
REQ-017 SHALL send 4 bytes per register, ordered per LSB_FIRST.
REQ-018 SHALL, with tx_ready held at 1, sustain 5 cycles per register and 32*5 cycles for a full 0..31 dump (base build).
REQ-019 SHALL advance the index modulo 32; lo_idx > hi_idx therefore wraps through 31 to 0 and ends at hi.
REQ-020 SHALL, when lo_idx == hi_idx, dump exactly one register.
REQ-021 SHALL make each word a snapshot at its own LOAD cycle; register-file writes during SEND do not alter bytes already captured.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL pulse done in the cycle the state returns to IDLE; a start in that same cycle is ignored.
REQ-024 SHALL send index 0 with whatever reg_data returns for it (0 from the register file), with no special-casing.

Reset
REQ-025 SHALL, on rst, immediately force state IDLE, reg_sel=0, tx_data=0, tx_valid=0, busy=0, done=0, index=0 and shift register=0.
REQ-026 SHALL, on rst mid-dump, drop the transfer without completion and without a done pulse; the next start begins a fresh dump.

Configuration
REQ-027 SHALL support macro RF_DUMP_INDEX_EN.
- Defined: each register is prefixed by a header byte {3'b000, index}, giving 5 bytes and 6 cycles per register.
- Undefined: no header; 4 bytes per register; header logic absent.

Structure
REQ-028 SHALL place the state enum, BYTES_PER_WORD=4 and the header-format constant in the shared package rf_dump_pkg.
REQ-029 SHALL implement the byte serializer (shift register, byte counter, valid/ready hold) as sub-module rf_dump_ser; rf_dump holds the sequencing FSM.

Verification
REQ-030 Bench SHALL cover: x1..x31 preset to 0x100+i, start with lo=0, hi=31, tx_ready=1 -> 128 bytes; x5 bytes are 05 01 00 00; done at cycle 161 after start.
REQ-031 Bench SHALL cover: lo=30, hi=1, x30=0xDEADBEEF, LSB_FIRST=0 -> registers 30,31,0,1 in order; first bytes DE AD BE EF; x0 sends 00 00 00 00.
REQ-032 Bench SHALL cover: tx_ready toggling 1,0,0,1 during SEND -> tx_data/tx_valid unchanged while stalled; no byte lost or duplicated.
REQ-033 Bench SHALL cover: write x3=0x55 during the SEND of x3, lo=hi=3 -> old value transmitted; second dump sends 55 00 00 00.
REQ-034 Bench SHALL cover: rst asserted after the 2nd byte of a dump -> tx_valid=0 and busy=0 asynchronously; no done; a following start produces a complete dump.
REQ-035 Bench SHALL cover: RF_DUMP_INDEX_EN defined, lo=hi=7, x7=0x12345678 -> 07 78 56 34 12; done 6 cycles after LOAD begins.
